// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding and counter sizing.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // A 1-bit operand still needs a 1-bit counter so the compare has something to look at.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder, purely combinational.
// Zero latency; no handshake or backpressure.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (a & c_in) | (b & c_in);

endmodule

// File: rtl/serial_adder.sv
// LSB-first bit-serial add/subtract using one full_adder slice and a carry flop.
// done pulses the cycle after the WIDTH-th shift edge; start is ignored while busy, not queued.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_sr_q, res_sr_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;

    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH:0]   res_ext;

    full_adder u_fa (
        .a     (a_sr_q[0]),
        .b     (b_sr_q[0]),
        .c_in  (carry_q),
        .sum   (fa_sum),
        .c_out (fa_cout)
    );

    // New bit enters at the MSB; the extra bit keeps the shift legal for WIDTH=1.
    assign res_ext = {fa_sum, res_sr_q};

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        c_out_d  = c_out_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    // Subtraction is a + ~b + 1, so c_in is replaced by the forced 1.
                    a_sr_d  = a;
                    b_sr_d  = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : c_in;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                res_sr_d = res_ext[WIDTH:1];
                carry_d  = fa_cout;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    // carry_q is still the carry into the MSB on this edge.
                    sum_d   = res_ext[WIDTH:1];
                    c_out_d = fa_cout;
                    ovf_d   = carry_q ^ fa_cout;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            c_out_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            c_out_q  <= c_out_d;
            ovf_q    <= ovf_d;
        end
    end

    assign sum      = sum_q;
    assign c_out    = c_out_q;
    assign overflow = ovf_q;
    assign busy     = (state_q == S_SHIFT);
    assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder at WIDTH=1, 8 and 16 against an integer-arithmetic reference model.
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  start;
    logic        sub_in;
    logic        cin_in;
    logic [15:0] a_in;
    logic [15:0] b_in;

    logic        sum1;
    logic        c1, o1, busy1, done1;
    logic [7:0]  sum8;
    logic        c8, o8, busy8, done8;
    logic [15:0] sum16;
    logic        c16, o16, busy16, done16;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(1)) dut1 (
        .clock(clk), .reset(reset), .start(start[0]), .sub(sub_in),
        .a(a_in[0]), .b(b_in[0]), .c_in(cin_in),
        .sum(sum1), .c_out(c1), .overflow(o1), .busy(busy1), .done(done1)
    );

    serial_adder #(.WIDTH(8)) dut8 (
        .clock(clk), .reset(reset), .start(start[1]), .sub(sub_in),
        .a(a_in[7:0]), .b(b_in[7:0]), .c_in(cin_in),
        .sum(sum8), .c_out(c8), .overflow(o8), .busy(busy8), .done(done8)
    );

    serial_adder #(.WIDTH(16)) dut16 (
        .clock(clk), .reset(reset), .start(start[2]), .sub(sub_in),
        .a(a_in), .b(b_in), .c_in(cin_in),
        .sum(sum16), .c_out(c16), .overflow(o16), .busy(busy16), .done(done16)
    );

    // Reference: unsigned sum gives result and carry, signed sum gives overflow.
    function automatic void model(input int w, input logic s, input logic [15:0] a,
                                  input logic [15:0] b, input logic ci,
                                  output logic [15:0] es, output logic ec, output logic eo);
        longint m, ua, ub, sa, sb, u, sr, c;
        m  = longint'(1) << w;
        ua = longint'(a) & (m - 1);
        ub = longint'(b) & (m - 1);
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        c  = ci ? 1 : 0;
        if (!s) begin
            u  = ua + ub + c;
            sr = sa + sb + c;
            ec = (u >= m);
        end else begin
            u  = ua - ub;
            sr = sa - sb;
            ec = (ua >= ub);
        end
        es = 16'(u & (m - 1));
        eo = (sr >= m / 2) || (sr < -(m / 2));
    endfunction

    function automatic logic get_busy(input int w);
        case (w)
            1:       return busy1;
            8:       return busy8;
            default: return busy16;
        endcase
    endfunction

    function automatic logic get_done(input int w);
        case (w)
            1:       return done1;
            8:       return done8;
            default: return done16;
        endcase
    endfunction

    function automatic logic [17:0] get_res(input int w);
        case (w)
            1:       return {c1, o1, 15'd0, sum1};
            8:       return {c8, o8, 8'd0, sum8};
            default: return {c16, o16, sum16};
        endcase
    endfunction

    task automatic set_start(input int w, input logic v);
        case (w)
            1:       start[0] = v;
            8:       start[1] = v;
            default: start[2] = v;
        endcase
    endtask

    // One operation: accept, then expect done exactly w edges later with outputs held meanwhile.
    task automatic run_op(input int w, input logic s, input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input string tag);
        logic [15:0] es;
        logic        ec, eo;
        logic [17:0] held, got;
        int          n;
        bit          stable;
        model(w, s, a, b, ci, es, ec, eo);
        @(negedge clk);
        sub_in = s; a_in = a; b_in = b; cin_in = ci;
        set_start(w, 1'b1);
        @(posedge clk);
        #1;
        set_start(w, 1'b0);
        held   = get_res(w);
        stable = 1;
        n      = 0;
        checks++;
        if (get_busy(w) !== 1'b1) begin
            failures++;
            $display("FAIL %s busy_after_accept w=%0d got=%b want=1", tag, w, get_busy(w));
        end
        for (int i = 1; i <= w + 4; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (get_busy(w) && get_done(w)) begin
                failures++;
                $display("FAIL %s busy_and_done w=%0d cycle=%0d", tag, w, i);
            end
            if (get_done(w) === 1'b1) begin
                n = i;
                break;
            end
            if (get_res(w) !== held) stable = 0;
        end
        checks++;
        if (n != w) begin
            failures++;
            $display("FAIL %s latency w=%0d got=%0d want=%0d", tag, w, n, w);
        end
        checks++;
        if (!stable) begin
            failures++;
            $display("FAIL %s outputs_moved_while_busy w=%0d", tag, w);
        end
        got = get_res(w);
        checks++;
        if (got !== {ec, eo, es}) begin
            failures++;
            $display("FAIL %s result w=%0d s=%b a=%h b=%h ci=%b got c=%b o=%b sum=%h want c=%b o=%b sum=%h",
                     tag, w, s, a, b, ci, got[17], got[16], got[15:0], ec, eo, es);
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        start  = 3'b111;
        sub_in = 1'b0; cin_in = 1'b1;
        a_in   = 16'h1234; b_in = 16'h4321;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({sum8, c8, o8, busy8, done8} !== 12'd0) begin
            failures++;
            $display("FAIL reset_outputs got sum=%h c=%b o=%b busy=%b done=%b want all 0",
                     sum8, c8, o8, busy8, done8);
        end
        checks++;
        if ({sum16, busy16, done16, sum1, busy1, done1} !== 21'd0) begin
            failures++;
            $display("FAIL reset_outputs_w16_w1 got sum16=%h sum1=%b busy/done nonzero", sum16, sum1);
        end
        @(negedge clk);
        start = 3'b000;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (done8 !== 1'b0 || busy8 !== 1'b0) begin
                failures++;
                $display("FAIL idle_after_reset cycle=%0d got busy=%b done=%b want 0 0", i, busy8, done8);
            end
        end
    endtask

    task automatic test_add();
        run_op(8, 1'b0, 16'h5A, 16'h3C, 1'b0, "add_5a_3c");
        run_op(8, 1'b0, 16'hFF, 16'h01, 1'b0, "add_ff_01");
        run_op(8, 1'b0, 16'h7F, 16'h00, 1'b1, "add_7f_cin");
        for (int i = 0; i < 30; i++)
            run_op(8, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom), "add_rand");
    endtask

    task automatic test_sub();
        run_op(8, 1'b1, 16'h10, 16'h20, 1'b1, "sub_10_20");
        run_op(8, 1'b1, 16'h80, 16'h01, 1'b0, "sub_80_01");
        for (int i = 0; i < 30; i++)
            run_op(8, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom), "sub_rand");
    endtask

    task automatic test_start_ignored();
        logic [15:0] es;
        logic        ec, eo;
        int          n;
        model(8, 1'b0, 16'h21, 16'h43, 1'b1, es, ec, eo);
        @(negedge clk);
        sub_in = 1'b0; a_in = 16'h21; b_in = 16'h43; cin_in = 1'b1;
        start[1] = 1'b1;
        @(posedge clk);
        #1;
        start[1] = 1'b0;
        n = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 3) begin
                sub_in = 1'b1; a_in = 16'hEE; b_in = 16'h99; cin_in = 1'b0;
                start[1] = 1'b1;
            end else begin
                start[1] = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done8 === 1'b1) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n != 8) begin
            failures++;
            $display("FAIL ignored_start_latency got=%0d want=8", n);
        end
        checks++;
        if ({c8, o8, sum8} !== {ec, eo, es[7:0]}) begin
            failures++;
            $display("FAIL ignored_start_result got c=%b o=%b sum=%h want c=%b o=%b sum=%h",
                     c8, o8, sum8, ec, eo, es[7:0]);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (busy8 !== 1'b0 || done8 !== 1'b0) begin
                failures++;
                $display("FAIL ignored_start_queued cycle=%0d got busy=%b done=%b want 0 0", i, busy8, done8);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] expq[$];
        logic [15:0] es;
        logic        ec, eo, s;
        logic [15:0] a, b;
        int          ndone, last, cyc;
        logic        prev_done;
        ndone = 0; last = 0; cyc = 0; prev_done = 0;
        s = 1'($urandom); a = 16'($urandom); b = 16'($urandom);
        model(8, s, a, b, 1'b0, es, ec, eo);
        expq.push_back({ec, eo, 8'd0, es[7:0]});
        @(negedge clk);
        sub_in = s; a_in = a; b_in = b; cin_in = 1'b0;
        start[1] = 1'b1;
        while (cyc < 80 && ndone < 5) begin
            @(posedge clk);
            #1;
            cyc++;
            checks++;
            if ((busy8 && done8) || (prev_done && done8)) begin
                failures++;
                $display("FAIL b2b_done_overlap cycle=%0d busy=%b done=%b prev_done=%b", cyc, busy8, done8, prev_done);
            end
            prev_done = done8;
            if (done8 === 1'b1) begin
                checks++;
                if (cyc - last != 9) begin
                    failures++;
                    $display("FAIL b2b_interval got=%0d want=9", cyc - last);
                end
                last = cyc;
                checks++;
                if ({c8, o8, 8'd0, sum8} !== expq[0]) begin
                    failures++;
                    $display("FAIL b2b_result op=%0d got c=%b o=%b sum=%h want %h",
                             ndone, c8, o8, sum8, expq[0]);
                end
                void'(expq.pop_front());
                ndone++;
                if (ndone < 5) begin
                    s = 1'($urandom); a = 16'($urandom); b = 16'($urandom);
                    model(8, s, a, b, 1'b1, es, ec, eo);
                    expq.push_back({ec, eo, 8'd0, es[7:0]});
                    sub_in = s; a_in = a; b_in = b; cin_in = 1'b1;
                end else begin
                    start[1] = 1'b0;
                end
            end
        end
        start[1] = 1'b0;
        checks++;
        if (ndone != 5) begin
            failures++;
            $display("FAIL b2b_count got=%0d want=5", ndone);
        end
    endtask

    task automatic test_reset_mid();
        run_op(8, 1'b0, 16'h5A, 16'h3C, 1'b0, "pre_reset");
        @(negedge clk);
        sub_in = 1'b0; a_in = 16'h11; b_in = 16'h22; cin_in = 1'b0;
        start[1] = 1'b1;
        @(posedge clk);
        #1;
        start[1] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({sum8, c8, o8, busy8, done8} !== 12'd0) begin
            failures++;
            $display("FAIL mid_reset_outputs got sum=%h c=%b o=%b busy=%b done=%b want all 0",
                     sum8, c8, o8, busy8, done8);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (done8 !== 1'b0) begin
                failures++;
                $display("FAIL mid_reset_spurious_done cycle=%0d got=%b want=0", i, done8);
            end
        end
        run_op(8, 1'b1, 16'h05, 16'h09, 1'b0, "post_reset");
    endtask

    task automatic test_width1();
        for (int k = 0; k < 16; k++) begin
            logic [3:0] v;
            v = 4'(k);
            run_op(1, v[3], {15'd0, v[2]}, {15'd0, v[1]}, v[0], "w1_exh");
        end
    endtask

    task automatic test_width16();
        for (int i = 0; i < 1000; i++)
            run_op(16, 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), "w16_rand");
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        test_width1();
        test_width16();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
